xbar_ingress_framer: RTL

Per-port ingress framer for the 8x8 time-space crossbar switch. It accepts header/payload packet pairs from a host-side source over a valid/ready handshake and buffers them in a small FIFO. It serializes one packet per time slot, MSB first, onto the switch's per-port `serial_in` line, aligned to the frame sync produced by control logic. One instance per port sits directly upstream of the switch input logic.

---
 rtl/xbar_pkg.sv | 38 +++
 rtl/xbar_pkt_fifo.sv | 60 ++++++
 rtl/xbar_ingress_framer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/xbar_pkg.sv
// Shared constants and types for the 8x8 time-space crossbar ingress path.
package xbar_pkg;

    localparam int unsigned NUM_SLOTS = 8;
    localparam int unsigned NUM_PORTS = 8;

    // Header field positions
    localparam int unsigned VALID_BIT = 7;
    localparam int unsigned SLOT_MSB  = 5;
    localparam int unsigned SLOT_LSB  = 3;
    localparam int unsigned PORT_MSB  = 2;
    localparam int unsigned PORT_LSB  = 0;

    localparam int unsigned SLOT_BITS = 16;
    localparam logic [SLOT_BITS-1:0] IDLE_WORD = 16'h0000;

    typedef struct packed {
        logic       valid;
        logic       rsvd;
        logic [2:0] dst_slot;
        logic [2:0] dst_port;
    } packet;

    typedef enum logic {
        StIdle,
        StRun
    } framer_state_e;

    // Builds the on-wire slot word; the header valid bit is always set on transmit.
    function automatic logic [SLOT_BITS-1:0] slot_word(input packet hdr,
                                                       input logic [7:0] payload);
        logic [7:0] h;
        h = hdr;
        h[VALID_BIT] = 1'b1;
        return {h, payload};
    endfunction

endpackage

// File: rtl/xbar_pkt_fifo.sv
// Synchronous packet FIFO with full/empty/level; head is read directly from storage registers.
module xbar_pkt_fifo
    import xbar_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = SLOT_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == FULL_LEVEL);
    assign o_empty = (r_level == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/xbar_ingress_framer.sv
// Per-port ingress framer: buffers header/payload pairs and serializes one packet per
// time slot, MSB first, aligned to the crossbar frame sync.
module xbar_ingress_framer
    import xbar_pkg::*;
#(
    parameter int unsigned SLOTS      = NUM_SLOTS,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_sync,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  in_header,
    input  logic [7:0]                  in_payload,
    output logic                        ser_out,
    output logic [$clog2(SLOTS)-1:0]    slot_idx,
    output logic                        frame_active,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                  underrun_count,
    output logic [7:0]                  resync_count
);

    localparam int unsigned SW = $clog2(SLOTS);
    localparam int unsigned BW = $clog2(SLOT_BITS);
    localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(SLOT_BITS - 1);

    framer_state_e          r_state;
    framer_state_e          w_state_next;
    logic [SLOT_BITS-1:0]   r_shreg;
    logic [BW-1:0]          r_bit_cnt;
    logic [SW-1:0]          r_slot_idx;
    logic [7:0]             r_underrun;
    logic [7:0]             r_resync;

    logic                   w_load;
    logic                   w_resync;
    logic                   w_slot_inc;
    logic                   w_last_bit;
    logic                   w_last_slot;
    logic                   w_full;
    logic                   w_empty;
    logic [SLOT_BITS-1:0]   w_head;
    logic [SLOT_BITS-1:0]   w_wdata;
    logic                   w_run;

    assign w_wdata = slot_word(packet'(in_header), in_payload);

    // Pop is gated on empty inside the FIFO, so an empty load never consumes a same-cycle push.
    xbar_pkt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SLOT_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_wdata (w_wdata),
        .i_pop   (w_load),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign in_ready       = !w_full;
    assign slot_idx       = r_slot_idx;
    assign underrun_count = r_underrun;
    assign resync_count   = r_resync;
    assign w_last_bit     = (r_bit_cnt == LAST_BIT);
    assign w_last_slot    = (r_slot_idx == LAST_SLOT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_resync     = 1'b0;
        w_slot_inc   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (frame_sync) begin
                    w_state_next = StRun;
                    w_load       = 1'b1;
                end
            end
            StRun: begin
                if (w_last_bit && w_last_slot) begin
                    if (frame_sync) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = StIdle;
                    end
                end else if (frame_sync) begin
                    // Sync anywhere but the frame boundary abandons the in-flight slot.
                    w_load   = 1'b1;
                    w_resync = 1'b1;
                end else if (w_last_bit) begin
                    w_load     = 1'b1;
                    w_slot_inc = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_run        = (r_state == StRun);
        frame_active = w_run;
        ser_out      = w_run && r_shreg[SLOT_BITS-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg    <= IDLE_WORD;
            r_bit_cnt  <= '0;
            r_slot_idx <= '0;
            r_underrun <= '0;
            r_resync   <= '0;
        end else begin
            if (w_load) begin
                r_shreg    <= w_empty ? IDLE_WORD : w_head;
                r_bit_cnt  <= '0;
                r_slot_idx <= w_slot_inc ? r_slot_idx + 1'b1 : '0;
            end else if (w_state_next == StRun) begin
                r_shreg   <= {r_shreg[SLOT_BITS-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end else begin
                r_shreg    <= IDLE_WORD;
                r_bit_cnt  <= '0;
                r_slot_idx <= '0;
            end

            if (w_load && w_empty && (r_underrun != 8'hFF)) begin
                r_underrun <= r_underrun + 8'd1;
            end
            if (w_resync && (r_resync != 8'hFF)) begin
                r_resync <= r_resync + 8'd1;
            end
        end
    end

endmodule
